// File: rtl/leaf_stream_fifo.sv
// leaf_stream_fifo: circular byte-stream FIFO between two valid/ready siblings.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data upstream;
// out_valid/out_ready/out_data downstream; level occupancy; xfer_count
// saturating count of completed output handshakes.
module leaf_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         xfer_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [LW-1:0]    lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // in_ready is independent of out_ready: no comb path through the block
  assign in_ready  = !rst && (lvl_q != FULL);
  assign out_valid = (lvl_q != '0);
  assign out_data  = mem_q[rd_q];
  assign level      = lvl_q;
  assign xfer_count = cnt_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    if (push) wr_d = wr_q + PW'(1);
    if (pop) begin
      rd_d = rd_q + PW'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end
    unique case ({push, pop})
      2'b10:   lvl_d = lvl_q + LW'(1);
      2'b01:   lvl_d = lvl_q - LW'(1);
      default: lvl_d = lvl_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  // storage is not reset; push already excludes reset cycles
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= in_data;
  end

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// tb_leaf_stream_fifo: queue-model scoreboard for leaf_stream_fifo,
// directed scenarios followed by randomized traffic and resets.
module tb_leaf_stream_fifo;

  localparam int D = 4;

  logic       clk = 0;
  logic       rst = 1;
  logic       in_valid = 0;
  logic       out_ready = 0;
  logic [7:0] in_data = 0;

  logic       in_ready, out_valid;
  logic [7:0] out_data;
  logic [2:0] level;
  logic [15:0] xfer_count;

  logic       s_in_ready, s_out_valid;
  logic [7:0] s_out_data;
  logic [2:0] s_level;
  logic [3:0] s_xfer;

  leaf_stream_fifo dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .xfer_count(xfer_count)
  );

  leaf_stream_fifo #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .level(s_level), .xfer_count(s_xfer)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [7:0] q[$];
  logic [7:0] outs[$];
  int unsigned cnt = 0;
  bit armed = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  function automatic logic [31:0] got(int i);
    if (i < outs.size()) return {24'h0, outs[i]};
    return 32'hFFFF_FFFF;
  endfunction

  // reference model: plain queue of accepted words
  always @(posedge clk) begin
    bit ps, pp;
    if (rst) begin
      q.delete();
      cnt = 0;
      armed = 1;
    end else begin
      ps = in_valid && (q.size() < D);
      pp = out_ready && (q.size() > 0);
      if (pp) begin
        outs.push_back(q.pop_front());
        cnt++;
      end
      if (ps) q.push_back(in_data);
    end
  end

  // monitor: compare DUT against model away from the active edge
  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        chk("rst_in_ready", {31'h0, in_ready}, 0);
      end else begin
        chk("in_ready", {31'h0, in_ready}, {31'h0, q.size() < D});
        chk("out_valid", {31'h0, out_valid}, {31'h0, q.size() > 0});
        chk("level", {29'h0, level}, q.size());
        chk("xfer", {16'h0, xfer_count}, cnt > 65535 ? 65535 : cnt);
        chk("xfer_small", {28'h0, s_xfer}, cnt > 15 ? 15 : cnt);
        chk("s_level", {29'h0, s_level}, q.size());
        if (q.size() > 0) begin
          chk("out_data", {24'h0, out_data}, {24'h0, q[0]});
          chk("s_out_data", {24'h0, s_out_data}, {24'h0, q[0]});
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    step(2);
    rst = 0;
    @(negedge clk);
    chk("reset_in_ready", {31'h0, in_ready}, 1);
    chk("reset_out_valid", {31'h0, out_valid}, 0);
    chk("reset_level", {29'h0, level}, 0);
    chk("reset_xfer", {16'h0, xfer_count}, 0);

    // fill with out_ready low
    for (int i = 0; i < 4; i++) begin
      in_valid = 1;
      in_data  = 8'((i + 1) * 8'h11);
      step(1);
    end
    in_data = 8'h55;
    step(3);
    @(negedge clk);
    chk("full_level", {29'h0, level}, 4);
    chk("full_in_ready", {31'h0, in_ready}, 0);
    chk("full_head", {24'h0, out_data}, 8'h11);
    in_valid = 0;

    // drain
    outs.delete();
    out_ready = 1;
    step(1);
    @(negedge clk);
    chk("ready_after_pop", {31'h0, in_ready}, 1);
    step(3);
    out_ready = 0;
    @(negedge clk);
    chk("drain_level", {29'h0, level}, 0);
    chk("drain_valid", {31'h0, out_valid}, 0);
    chk("drain_xfer", {16'h0, xfer_count}, 4);
    chk("drain_o0", got(0), 8'h11);
    chk("drain_o1", got(1), 8'h22);
    chk("drain_o2", got(2), 8'h33);
    chk("drain_o3", got(3), 8'h44);
    chk("drain_cnt", outs.size(), 4);

    // streaming and wrap
    rst = 1;
    step(1);
    rst = 0;
    outs.delete();
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      step(1);
    end
    in_valid = 0;
    step(1);
    @(negedge clk);
    chk("stream_xfer", {16'h0, xfer_count}, 10);
    chk("stream_n", outs.size(), 10);
    for (int i = 0; i < 10; i++) chk("stream_word", got(i), i);

    // saturation on the CNT_W=4 instance
    in_valid = 1;
    for (int i = 10; i < 20; i++) begin
      in_data = 8'(i);
      step(1);
    end
    in_valid = 0;
    step(1);
    @(negedge clk);
    chk("sat_big", {16'h0, xfer_count}, 20);
    chk("sat_small", {28'h0, s_xfer}, 15);

    // mid-stream reset
    out_ready = 0;
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'hC0 + 8'(i);
      step(1);
    end
    @(negedge clk);
    chk("mid_level3", {29'h0, level}, 3);
    rst = 1;
    step(1);
    rst = 0;
    in_valid = 0;
    @(negedge clk);
    chk("mid_level0", {29'h0, level}, 0);
    chk("mid_valid", {31'h0, out_valid}, 0);
    chk("mid_xfer", {16'h0, xfer_count}, 0);
    in_valid = 1;
    in_data = 8'hA5;
    step(1);
    in_valid = 0;
    outs.delete();
    out_ready = 1;
    step(2);
    @(negedge clk);
    chk("mid_first", got(0), 8'hA5);
    chk("mid_n", outs.size(), 1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 99) == 0);
      step(1);
    end
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    step(6);
    @(negedge clk);
    chk("final_empty", {31'h0, out_valid}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
